grant_sequencer: RTL and testbench
==================================

# grant_sequencer

Sequential grant stage that sits directly downstream of the 8-input fixed-priority arbiter. It latches raw request pulses into a pending register and issues one registered one-hot grant at a time, selecting the lowest-numbered pending bit. Each grant is held until the granted client signals `done`. It also supplies the encoded grant index to the shared-resource mux that follows it.

## Interface

Parameters:
- `MAX_HOLD`, default 16: maximum grant length in cycles, used only when the timeout is compiled in. Legal range is 2–255.

Ports:
- `clk` input, 1 bit: single clock. All logic is rising-edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req` input, 8 bits: request inputs. A bit that is high at a clock edge sets the matching pending bit. Both pulses and levels are accepted.
- `done` input, 1 bit: the current grantee releases the resource.
- `grant` output, 8 bits: registered one-hot grant. It is all zeros when no grant is active.
- `grant_idx` output, 3 bits: binary index of the active grant bit. It is 0 when idle.
- `grant_valid` output, 1 bit: high while a grant is active. It equals `|grant`.
- `pending` output, 8 bits: registered pending-request vector.
- `timeout` output, 1 bit: one-cycle pulse when a grant is revoked by the watchdog.

## Operation

- State machine has two states: `IDLE` and `BUSY`.
- Pending register update on every edge: `pending <= (pending & ~clr) | req`.
  - `clr` is the one-hot grant being issued on that edge, and is 0 otherwise.
  - `req` has priority over `clr`. A request on the bit being granted in the same cycle stays pending and is served again later.
- `IDLE`, when `pending != 0`:
  - Select the lowest set bit of the registered `pending` (bit 0 is the highest priority).
  - Load `grant`, `grant_idx` and `grant_valid=1`.
  - Clear that pending bit.
  - Move to `BUSY`.
  - New `req` bits arriving on this same edge are not considered for this selection.
- `IDLE`, when `pending == 0`: outputs hold at zero.
- `done` is ignored while in `IDLE`.
- `BUSY`, when `done=1`:
  - Clear `grant`, `grant_idx` and `grant_valid`.
  - Move to `IDLE`.
  - There is always at least one idle cycle between consecutive grants, even when `pending` is nonzero.
- `BUSY`, when `done=0`: the grant is held unchanged. Requests keep accumulating in `pending`.
- Hold counter (8 bits, only with timeout enabled):
  - Reset to 0 on entry to `BUSY`.
  - Increments every cycle spent in `BUSY`.
  - Saturates; it does not wrap.
- Reset, when `rst_n=0` at an edge, from any state including mid-grant:
  - `state=IDLE`.
  - `grant=0`, `grant_idx=0`, `grant_valid=0`, `pending=0`, `timeout=0`, counter 0.
  - `req` is ignored on reset edges.

## Timing

- Reset value of all outputs is 0.
- Request-to-grant latency, when idle and `pending=0`:
  - `req` sampled at edge k sets `pending` after edge k.
  - `grant` is valid after edge k+1.
  - Total latency is 2 edges.
- Grant duration is at least 1 cycle.
  - `done` sampled at edge j deasserts the grant after edge j.
  - A `done` held continuously from the grant edge gives a 1-cycle grant.
- Re-grant: the earliest next grant is after edge j+1.
- `grant`, `grant_idx` and `grant_valid` always change together on the same edge. They never glitch, because all are registered.
- `timeout` is high for exactly the one cycle following a revoke edge.

## Configuration

- Macro: `GRANT_TIMEOUT_EN`.
- Defined:
  - In `BUSY` with `done=0` and hold counter equal to `MAX_HOLD-1`, the next edge revokes the grant exactly as `done` would.
  - On that edge, `timeout` is set for one cycle.
  - The grant therefore lasts `MAX_HOLD` cycles at most.
  - If `done=1` on the same edge as the timeout condition, it is treated as a normal release and `timeout` stays 0.
- Undefined:
  - No counter logic is built.
  - `timeout` is tied to 0.
  - A grant is held indefinitely until `done`.

## Test plan

- Reset mid-grant: grant `8'h04` active, drive `rst_n=0` for one edge → all outputs 0, `pending=0`. Re-request `8'h04` → grant returns 2 edges later.
- Simultaneous requests: `req=8'hA4` pulsed one cycle. Pulse `done` 1 cycle after each grant → grants issue in order `8'h04`, `8'h20`, `8'h80`, each with `grant_idx` 2, 5, 7. One idle cycle separates each grant. `pending` steps `A4`→`A0`→`80`→`00`.
- Priority preemption of the queue: grant `8'h08` active, pending `8'h40`. Pulse `req=8'h01` before `done` → the next grant after `done` is `8'h01`, then `8'h40`.
- Same-bit re-request: `req=8'h02` held high continuously → grant `8'h02` is reissued after each `done`, and `pending[1]` stays 1.
- `done` in `IDLE`: pulse `done` with `pending=0` → no state change, all outputs remain 0.
- Timeout (`GRANT_TIMEOUT_EN`, `MAX_HOLD=4`): `req=8'h10`, never assert `done` → `grant=8'h10` for exactly 4 cycles, then 0, `timeout` high 1 cycle. Without the macro, the grant holds for 100+ cycles and `timeout` stays 0.

Source files
------------

// File: rtl/grant_sequencer_if.sv
// grant_sequencer_if: request/grant bundle between clients and the grant sequencer.
interface grant_sequencer_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic [7:0] pending;
    logic       timeout;
    modport master (output req, output done, input grant, input grant_idx, input grant_valid, input pending, input timeout);
    modport slave  (input req, input done, output grant, output grant_idx, output grant_valid, output pending, output timeout);
endinterface

// File: rtl/grant_sequencer.sv
// grant_sequencer: latches requests and issues one registered one-hot grant at a time, lowest index first.
// Optional hold watchdog enabled by defining GRANT_TIMEOUT_EN.
module grant_sequencer #(
    parameter int MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst_n,
    grant_sequencer_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     r_state;
    logic [7:0] r_grant;
    logic [2:0] r_idx;
    logic       r_valid;
    logic [7:0] r_pending;
    logic [7:0] w_sel;
    logic [7:0] w_clr;
    logic [2:0] w_idx;
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range 2..255");
    end
    assign w_sel = r_pending & (~r_pending + 8'd1);
    assign w_clr = (r_state == IDLE) ? w_sel : 8'd0;
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (r_pending[i]) w_idx = 3'(i);
    end
`ifdef GRANT_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timeout;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= 8'd0;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_pending <= 8'd0;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | bus.req;
            r_timeout <= 1'b0;
            if (r_state == IDLE) begin
                if (r_pending != 8'd0) begin
                    r_state <= BUSY;
                    r_grant <= w_sel;
                    r_idx   <= w_idx;
                    r_valid <= 1'b1;
                    r_cnt   <= 8'd0;
                end
            end else if (bus.done || r_cnt == 8'(MAX_HOLD - 1)) begin
                // done wins over the watchdog, so a same-edge release is not a timeout
                r_state   <= IDLE;
                r_grant   <= 8'd0;
                r_idx     <= 3'd0;
                r_valid   <= 1'b0;
                r_timeout <= !bus.done;
            end else begin
                r_cnt <= r_cnt + {7'd0, r_cnt != 8'hFF};
            end
        end
    end
    assign bus.timeout = r_timeout;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= 8'd0;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_pending <= 8'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | bus.req;
            if (r_state == IDLE) begin
                if (r_pending != 8'd0) begin
                    r_state <= BUSY;
                    r_grant <= w_sel;
                    r_idx   <= w_idx;
                    r_valid <= 1'b1;
                end
            end else if (bus.done) begin
                r_state <= IDLE;
                r_grant <= 8'd0;
                r_idx   <= 3'd0;
                r_valid <= 1'b0;
            end
        end
    end
    assign bus.timeout = 1'b0;
`endif
    assign bus.grant       = r_grant;
    assign bus.grant_idx   = r_idx;
    assign bus.grant_valid = r_valid;
    assign bus.pending     = r_pending;
endmodule

// File: tb/tb_grant_sequencer.sv
// tb_grant_sequencer: directed checks of grant order, latency, reset, re-request and hold/timeout behaviour.
module tb_grant_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    grant_sequencer_if bus ();
    grant_sequencer #(.MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] g, input logic [2:0] idx, input logic [7:0] p, input logic t);
        logic [20:0] obs;
        logic [20:0] exp;
        obs = {bus.grant, bus.grant_idx, bus.grant_valid, bus.pending, bus.timeout};
        exp = {g, idx, g != 8'd0, p, t};
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got grant=%h idx=%0d valid=%b pending=%h timeout=%b, want grant=%h idx=%0d valid=%b pending=%h timeout=%b",
                     tag, obs[20:13], obs[12:10], obs[9], obs[8:1], obs[0], exp[20:13], exp[12:10], exp[9], exp[8:1], exp[0]);
            $error("check %s", tag);
        end
    endtask

    initial begin
        bus.req = 8'd0;
        bus.done = 1'b0;
        tick(); tick();
        chk("reset", 8'h00, 0, 8'h00, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", 8'h00, 0, 8'h00, 0);
        bus.done = 1'b1;
        tick();
        chk("done_in_idle", 8'h00, 0, 8'h00, 0);
        bus.done = 1'b0;
        // simultaneous requests
        bus.req = 8'hA4;
        tick();
        chk("simul_pend", 8'h00, 0, 8'hA4, 0);
        bus.req = 8'h00;
        tick();
        chk("simul_g04", 8'h04, 2, 8'hA0, 0);
        bus.done = 1'b1;
        tick();
        chk("simul_rel1", 8'h00, 0, 8'hA0, 0);
        bus.done = 1'b0;
        tick();
        chk("simul_g20", 8'h20, 5, 8'h80, 0);
        bus.done = 1'b1;
        tick();
        chk("simul_rel2", 8'h00, 0, 8'h80, 0);
        bus.done = 1'b0;
        tick();
        chk("simul_g80", 8'h80, 7, 8'h00, 0);
        bus.done = 1'b1;
        tick();
        chk("simul_rel3", 8'h00, 0, 8'h00, 0);
        bus.done = 1'b0;
        // queue preemption by a higher-priority request
        bus.req = 8'h08;
        tick();
        chk("pre_pend", 8'h00, 0, 8'h08, 0);
        bus.req = 8'h40;
        tick();
        chk("pre_g08", 8'h08, 3, 8'h40, 0);
        bus.req = 8'h01;
        tick();
        chk("pre_hold", 8'h08, 3, 8'h41, 0);
        bus.req = 8'h00;
        bus.done = 1'b1;
        tick();
        chk("pre_rel", 8'h00, 0, 8'h41, 0);
        bus.done = 1'b0;
        tick();
        chk("pre_g01", 8'h01, 0, 8'h40, 0);
        bus.done = 1'b1;
        tick();
        chk("pre_rel2", 8'h00, 0, 8'h40, 0);
        bus.done = 1'b0;
        tick();
        chk("pre_g40", 8'h40, 6, 8'h00, 0);
        bus.done = 1'b1;
        tick();
        chk("pre_rel3", 8'h00, 0, 8'h00, 0);
        bus.done = 1'b0;
        // reset mid-grant, req ignored on the reset edge
        bus.req = 8'h04;
        tick();
        bus.req = 8'h00;
        tick();
        chk("rst_mid_g04", 8'h04, 2, 8'h00, 0);
        rst_n = 1'b0;
        bus.req = 8'h04;
        tick();
        chk("rst_mid_clear", 8'h00, 0, 8'h00, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_rereq_pend", 8'h00, 0, 8'h04, 0);
        bus.req = 8'h00;
        tick();
        chk("rst_rereq_g04", 8'h04, 2, 8'h00, 0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        // same-bit request held high
        bus.req = 8'h02;
        tick();
        chk("same_pend", 8'h00, 0, 8'h02, 0);
        tick();
        chk("same_g02a", 8'h02, 1, 8'h02, 0);
        bus.done = 1'b1;
        tick();
        chk("same_rel", 8'h00, 0, 8'h02, 0);
        bus.done = 1'b0;
        tick();
        chk("same_g02b", 8'h02, 1, 8'h02, 0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req = 8'h00;
        tick();
        chk("same_g02c", 8'h02, 1, 8'h00, 0);
        bus.done = 1'b1;
        tick();
        chk("same_end", 8'h00, 0, 8'h00, 0);
        bus.done = 1'b0;
        // hold / watchdog
        bus.req = 8'h10;
        tick();
        bus.req = 8'h00;
        tick();
        chk("hold_c1", 8'h10, 4, 8'h00, 0);
`ifdef GRANT_TIMEOUT_EN
        tick();
        chk("hold_c2", 8'h10, 4, 8'h00, 0);
        tick();
        chk("hold_c3", 8'h10, 4, 8'h00, 0);
        tick();
        chk("hold_c4", 8'h10, 4, 8'h00, 0);
        tick();
        chk("timeout_pulse", 8'h00, 0, 8'h00, 1);
        tick();
        chk("timeout_clear", 8'h00, 0, 8'h00, 0);
`else
        for (int i = 0; i < 110; i++) begin
            tick();
            chk("hold_forever", 8'h10, 4, 8'h00, 0);
        end
        bus.done = 1'b1;
        tick();
        chk("hold_release", 8'h00, 0, 8'h00, 0);
        bus.done = 1'b0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
